// File: rtl/rx_packet_buffer_pkg.sv
// Shared types and constants for the USB receive packet buffer.
package rx_packet_buffer_pkg;

  localparam int DEFAULT_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

endpackage

// File: rtl/rx_byte_mem.sv
// Byte array with one synchronous write port and one asynchronous read port.
module rx_byte_mem
  import rx_packet_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Deliberately not reset: content is only meaningful behind the pointers.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_packet_buffer.sv
// Circular receive buffer that collects one USB packet at a time and holds it for the host.
module rx_packet_buffer
  import rx_packet_buffer_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_packet_data,
  input  logic          store_rx_packet_data,
  input  logic [3:0]    rx_packet,
  input  logic          rx_data_ready,
  input  logic          rx_error,
  input  logic          flush,
  input  logic          get_rx_data,
  input  logic          packet_ack,
  output logic [7:0]    rx_data,
  output logic [CW-1:0] buffer_occupancy,
  output logic          buffer_empty,
  output logic          buffer_full,
  output logic          overrun,
  output logic          packet_ready,
  output logic [3:0]    packet_pid,
  output logic [CW-1:0] packet_len
);

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr, pkt_start;
  logic [CW-1:0] pkt_count;
  logic          store_acc, get_acc, abort, finish;
  logic [7:0]    mem_rdata;

  assign buffer_empty = (buffer_occupancy == '0);
  assign buffer_full  = (buffer_occupancy == CW'(DEPTH));
  assign packet_ready = (state == READY);
  assign rx_data      = buffer_empty ? 8'h00 : mem_rdata;

  // A concurrent get frees a slot, so a full buffer still accepts a store that cycle.
  always_comb begin
    get_acc    = get_rx_data && !buffer_empty;
    abort      = (state == RECV) && rx_error;
    store_acc  = store_rx_packet_data && !abort && (state != READY) &&
                 (!buffer_full || get_acc);
    finish     = (state != READY) && rx_data_ready && !abort;
    state_next = state;
    case (state)
      IDLE: begin
        if (finish)         state_next = READY;
        else if (store_acc) state_next = RECV;
      end
      RECV: begin
        if (abort)       state_next = IDLE;
        else if (finish) state_next = READY;
      end
      READY: begin
        if (packet_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) state <= IDLE;
    else              state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pkt_start        <= '0;
      buffer_occupancy <= '0;
      pkt_count        <= '0;
      overrun          <= 1'b0;
      if (rst) begin
        packet_pid <= 4'h0;
        packet_len <= '0;
      end
    end else begin
      overrun <= store_rx_packet_data && !store_acc && !abort;
      if (get_acc) rd_ptr <= rd_ptr + AW'(1);
      if (abort) begin
        // Roll back only the aborted packet; earlier packets stay intact.
        wr_ptr           <= pkt_start;
        buffer_occupancy <= buffer_occupancy - pkt_count - CW'(get_acc);
        pkt_count        <= '0;
      end else begin
        buffer_occupancy <= buffer_occupancy + CW'(store_acc) - CW'(get_acc);
        if (store_acc) wr_ptr <= wr_ptr + AW'(1);
        if (state == IDLE && store_acc) begin
          pkt_start <= wr_ptr;
          pkt_count <= CW'(1);
        end else if (state == RECV && store_acc) begin
          pkt_count <= pkt_count + CW'(1);
        end
        if (finish) begin
          packet_pid <= rx_packet;
          packet_len <= ((state == RECV) ? pkt_count : '0) + CW'(store_acc);
        end
      end
    end
  end

  rx_byte_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (store_acc && !rst && !flush),
    .waddr (wr_ptr),
    .wdata (rx_packet_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Scoreboard bench for rx_packet_buffer: a queue-based packet model predicts status and popped bytes.
module tb_rx_packet_buffer;
  import rx_packet_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, store_rx_packet_data, rx_data_ready, rx_error, flush, get_rx_data, packet_ack;
  logic [7:0] rx_packet_data;
  logic [3:0] rx_packet;
  logic [7:0] rx_data;
  logic [6:0] buffer_occupancy, packet_len;
  logic       buffer_empty, buffer_full, overrun, packet_ready;
  logic [3:0] packet_pid;

  always #5 clk = ~clk;

  rx_packet_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_error             (rx_error),
    .flush                (flush),
    .get_rx_data          (get_rx_data),
    .packet_ack           (packet_ack),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_empty         (buffer_empty),
    .buffer_full          (buffer_full),
    .overrun              (overrun),
    .packet_ready         (packet_ready),
    .packet_pid           (packet_pid),
    .packet_len           (packet_len)
  );

  int         tests = 0;
  int         fails = 0;

  // Reference model: stored bytes as a FIFO queue plus packet bookkeeping.
  // mstate: 0 = waiting for a packet, 1 = receiving, 2 = packet held for the host.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         mstate = 0;
  int         mcount = 0;
  int         mlen   = 0;
  logic [3:0] mpid   = 4'h0;
  logic       movr   = 1'b0;

  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("occupancy", int'(buffer_occupancy), mq.size());
    checkVal("empty", int'(buffer_empty), int'(mq.size() == 0));
    checkVal("full", int'(buffer_full), int'(mq.size() == 64));
    checkVal("overrun", int'(overrun), int'(movr));
    checkVal("packet_ready", int'(packet_ready), int'(mstate == 2));
    checkVal("packet_pid", int'(packet_pid), int'(mpid));
    checkVal("packet_len", int'(packet_len), mlen);
    if (mq.size() == 0) checkVal("rx_data_when_empty", int'(rx_data), 0);
  endtask

  task automatic modelStep(input logic st, input logic [7:0] d, input logic [3:0] pid,
                           input logic rdy, input logic err, input logic fl,
                           input logic get, input logic ack);
    bit get_ok, abort, store_ok;
    if (fl) begin
      mq.delete();
      mstate = 0;
      mcount = 0;
      movr   = 1'b0;
      return;
    end
    get_ok   = get && (mq.size() > 0);
    abort    = (mstate == 1) && err;
    store_ok = st && !abort && (mstate != 2) && ((mq.size() < 64) || get_ok);
    movr     = st && !store_ok && !abort;
    if (get_ok) void'(mq.pop_front());
    if (abort) begin
      repeat (mcount) void'(mq.pop_back());
      mstate = 0;
      mcount = 0;
    end else begin
      if (store_ok) mq.push_back(d);
      case (mstate)
        0: begin
          if (rdy) begin
            mpid   = pid;
            mlen   = int'(store_ok);
            mcount = int'(store_ok);
            mstate = 2;
          end else if (store_ok) begin
            mstate = 1;
            mcount = 1;
          end
        end
        1: begin
          if (store_ok) mcount++;
          if (rdy) begin
            mpid   = pid;
            mlen   = mcount;
            mstate = 2;
          end
        end
        default: if (ack) mstate = 0;
      endcase
    end
  endtask

  // One clock of stimulus: drive, predict the popped byte, step the model at the edge, compare.
  task automatic applyStimulus(input logic st, input logic [7:0] d, input logic [3:0] pid,
                               input logic rdy, input logic err, input logic fl,
                               input logic get, input logic ack);
    store_rx_packet_data = st;
    rx_packet_data       = d;
    rx_packet            = pid;
    rx_data_ready        = rdy;
    rx_error             = err;
    flush                = fl;
    get_rx_data          = get;
    packet_ack           = ack;
    if (!fl && get && mq.size() > 0) exp_q.push_back(mq[0]);
    @(posedge clk);
    modelStep(st, d, pid, rdy, err, fl, get, ack);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input logic st);
    rst                  = 1'b1;
    store_rx_packet_data = st;
    rx_packet_data       = 8'h77;
    rx_data_ready        = 1'b0;
    rx_error             = 1'b0;
    flush                = 1'b0;
    get_rx_data          = 1'b0;
    packet_ack           = 1'b0;
    @(posedge clk);
    mq.delete();
    mstate = 0;
    mcount = 0;
    mlen   = 0;
    mpid   = 4'h0;
    movr   = 1'b0;
    #1;
    rst = 1'b0;
    store_rx_packet_data = 1'b0;
    checkOutput();
  endtask

  task automatic storeByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic endPacket(input logic [3:0] pid);
    applyStimulus(1'b0, 8'h00, pid, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic ackPacket();
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: whenever the DUT hands a byte to the host, it must be the next one predicted.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && flush === 1'b0 && get_rx_data === 1'b1 && buffer_empty === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL pop_unexpected: got byte %0h, expected no pop (t=%0t)", rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          checkVal("pop_data", int'(rx_data), int'(e));
        end
      end
    end
  endtask

  initial begin
    logic       st, rdy, err, fl, get, ack;
    logic [7:0] d;
    logic [3:0] pid;

    rst = 1'b1; store_rx_packet_data = 1'b0; rx_packet_data = 8'h00; rx_packet = 4'h0;
    rx_data_ready = 1'b0; rx_error = 1'b0; flush = 1'b0; get_rx_data = 1'b0; packet_ack = 1'b0;
    fork
      monitor();
    join_none

    doReset(1'b0);

    // Four-byte DATA0 packet, a dropped store while held, then drained in order.
    for (int i = 0; i < 4; i++) storeByte(8'hA1 + 8'(i));
    endPacket(PID_DATA0);
    checkVal("len_after_4", int'(packet_len), 4);
    checkVal("pid_data0", int'(packet_pid), int'(PID_DATA0));
    checkVal("ready_after_eop", int'(packet_ready), 1);
    storeByte(8'h55);
    checkVal("overrun_in_ready", int'(overrun), 1);
    checkVal("occ_after_drop", int'(buffer_occupancy), 4);
    for (int i = 0; i < 4; i++) popByte();
    ackPacket();
    checkVal("idle_after_ack", int'(packet_ready), 0);

    // Aborted packet after a retained two-byte packet.
    doReset(1'b0);
    storeByte(8'hB1); storeByte(8'hB2);
    endPacket(PID_DATA1);
    ackPacket();
    storeByte(8'hC1); storeByte(8'hC2); storeByte(8'hC3);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("occ_after_abort", int'(buffer_occupancy), 2);
    storeByte(8'hD1);
    endPacket(PID_ACK);
    checkVal("len_after_abort", int'(packet_len), 1);
    for (int i = 0; i < 3; i++) popByte();

    // Fill to capacity with one byte too many, then store+get while full.
    doReset(1'b0);
    for (int i = 0; i < 65; i++) storeByte(8'(i));
    checkVal("full_after_65", int'(buffer_full), 1);
    checkVal("overrun_on_65", int'(overrun), 1);
    idleCycle();
    checkVal("overrun_single", int'(overrun), 0);
    endPacket(PID_DATA0);
    checkVal("len_full", int'(packet_len), 64);
    ackPacket();
    applyStimulus(1'b1, 8'hEE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("occ_store_get_full", int'(buffer_occupancy), 64);
    endPacket(PID_DATA1);
    ackPacket();
    for (int i = 0; i < 64; i++) popByte();

    // Flush with a concurrent store, then the same with reset.
    doReset(1'b0);
    for (int i = 0; i < 10; i++) storeByte(8'h10 + 8'(i));
    applyStimulus(1'b1, 8'h99, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("occ_after_flush", int'(buffer_occupancy), 0);
    checkVal("empty_after_flush", int'(buffer_empty), 1);
    storeByte(8'h3C);
    endPacket(PID_DATA1);
    checkVal("len_after_flush", int'(packet_len), 1);
    ackPacket();
    popByte();
    for (int i = 0; i < 10; i++) storeByte(8'h20 + 8'(i));
    doReset(1'b1);
    checkVal("rst_pid", int'(packet_pid), 0);
    checkVal("rst_len", int'(packet_len), 0);
    checkVal("rst_rx_data", int'(rx_data), 0);
    checkVal("rst_full", int'(buffer_full), 0);
    checkVal("rst_overrun", int'(overrun), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      st  = 1'($urandom);
      d   = 8'($urandom);
      pid = 4'($urandom);
      get = ($urandom % 10) < 3;
      fl  = ($urandom % 100) == 0;
      rdy = 1'b0;
      err = 1'b0;
      ack = 1'b0;
      if (mstate == 1) begin
        int r;
        r = int'($urandom % 100);
        if (r < 5)      rdy = 1'b1;
        else if (r < 8) err = 1'b1;
        if (mq.size() <= mcount) get = 1'b0;
      end else if (mstate == 0) begin
        if (($urandom % 100) < 3) begin
          rdy = 1'b1;
          st  = 1'b0;
        end
      end else begin
        ack = ($urandom % 4) == 0;
      end
      applyStimulus(st, d, pid, rdy, err, fl, get, ack);
    end

    idleCycle();
    idleCycle();
    checkVal("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_packet_buffer.md
RX_PACKET_BUFFER -- requirements
Module: rx_packet_buffer

Interface
REQ-001 Parameter: DEPTH, 64, byte capacity of the buffer; power of two; occupancy width is log2(DEPTH)+1.
REQ-002 clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rx_packet_data  in  8  received byte from the USB RX stage.
REQ-005 store_rx_packet_data  in  1  one-cycle strobe: write rx_packet_data.
REQ-006 rx_packet  in  4  decoded PID from the USB RX stage.
REQ-007 rx_data_ready  in  1  one-cycle strobe: packet ended cleanly (EOP).
REQ-008 rx_error  in  1  one-cycle strobe: packet aborted.
REQ-009 flush  in  1  clear the buffer; highest priority.
REQ-010 get_rx_data  in  1  host pop strobe from the AHB side.
REQ-011 packet_ack  in  1  host releases the completed packet.
REQ-012 rx_data  out  8  head byte; 8'h00 when empty.
REQ-013 buffer_occupancy  out  7  stored byte count, 0..64.
REQ-014 buffer_empty / buffer_full  out  1 each  occupancy==0 / occupancy==DEPTH.
REQ-015 overrun  out  1  one-cycle pulse: a store was dropped.
REQ-016 packet_ready  out  1  high while in state READY.
REQ-017 packet_pid  out  4  PID latched at packet end.
REQ-018 packet_len  out  7  byte count of the latched packet.

Function
REQ-019 Storage SHALL be a circular byte array with 6-bit write and read pointers that wrap from 63 to 0; occupancy SHALL be a separate 7-bit counter.
REQ-020 FSM states SHALL be IDLE, RECV and READY.
REQ-021 IDLE->RECV on an accepted store, which SHALL also latch pkt_start=wr_ptr and clear pkt_count.
REQ-022 RECV: each accepted store SHALL increment pkt_count; on rx_data_ready the FSM SHALL latch packet_pid=rx_packet and packet_len=pkt_count (including a store in the same cycle) and move to READY.
REQ-023 IDLE with rx_data_ready (zero-byte token/handshake) SHALL latch rx_packet with packet_len=0 and move to READY.
REQ-024 RECV with rx_error SHALL rewind wr_ptr to pkt_start, subtract pkt_count from occupancy, and return to IDLE; bytes from earlier packets are preserved.
REQ-025 READY->IDLE on packet_ack; packet_pid and packet_len SHALL hold their values until the next latch.
REQ-026 A store SHALL be dropped, with overrun pulsed in the following cycle, when the buffer is full or the state is READY.
REQ-027 A get SHALL advance rd_ptr only when not empty; a get on empty SHALL be ignored.
REQ-028 A simultaneous store and get SHALL both take effect with occupancy unchanged; when full, both succeed; when empty, only the store succeeds.
REQ-029 Flush SHALL zero the pointers, occupancy and pkt_count and force IDLE in the next cycle, overriding any same-cycle store, get, rx_error or rx_data_ready.
REQ-030 All outputs except rx_data and the status flags SHALL be registered; store-to-visible-occupancy latency SHALL be 1 cycle.
REQ-031 rx_data SHALL present mem[rd_ptr] combinationally, masked to 8'h00 when empty.

Reset
REQ-032 On rst: pointers=0, occupancy=0, state=IDLE, overrun=0, packet_pid=4'h0, packet_len=0, rx_data=8'h00, buffer_empty=1, buffer_full=0.
REQ-033 Reset SHALL NOT clear the memory array.
REQ-034 Reset asserted mid-packet SHALL discard all content with no overrun pulse.

Structure
REQ-035 A shared package SHALL hold the state enum, the DEPTH default, and the PID constants (OUT, IN, DATA0, DATA1, ACK, NAK).
REQ-036 A single sub-module, rx_byte_mem (write port plus asynchronous read port), SHALL hold the array; the FSM and pointer logic SHALL reside in the top module.

Verification
REQ-037 Store bytes 8'hA1..8'hA4, then rx_data_ready with rx_packet=DATA0 -> packet_ready=1, packet_len=4, packet_pid=DATA0, occupancy=4; four gets return A1..A4 in order.
REQ-038 Store 3 bytes after one retained 2-byte packet, then rx_error -> occupancy=2, wr_ptr back at 2, state IDLE.
REQ-039 Store 65 bytes without rx_data_ready -> occupancy=64, buffer_full=1, a single overrun pulse, byte 65 absent.
REQ-040 With occupancy=64, assert store and get together -> occupancy stays 64, the oldest byte is removed, the new byte is stored at wrapped address 0.
REQ-041 In READY, store 8'h55 -> dropped and overrun pulsed; then packet_ack -> IDLE.
REQ-042 Assert flush together with a store at occupancy 10 -> next cycle occupancy=0, buffer_empty=1, state IDLE; repeat the sequence with rst and check every REQ-032 value.
